layer_index_sequencer: RTL

Generates the (output neuron, input element) index stream that drives one autoencoder layer's MAC datapath. After a `start` pulse it walks every input element of every output neuron under a valid/ready handshake, flagging the first and last term of each dot product. Its `out_idx` output feeds the 5-bit neuron-index register directly downstream, and its `done` pulse signals layer completion to the top-level controller.

---
 rtl/layer_index_sequencer_if.sv | 29 ++
 rtl/layer_index_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/layer_index_sequencer_if.sv
// Handshake/index bundle between the layer index sequencer and its MAC
// datapath. The sequencer drives the index stream; the consumer drives
// start and idx_ready.
`timescale 1ns/1ps
interface layer_index_sequencer_if #(
   parameter int CW = 5
) ();
   logic          start;
   logic          idx_ready;
   logic          idx_valid;
   logic [CW-1:0] in_idx;
   logic [CW-1:0] out_idx;
   logic          first;
   logic          last;
   logic          busy;
   logic          done;

   // sequencer side
   modport master (
      input  start, idx_ready,
      output idx_valid, in_idx, out_idx, first, last, busy, done
   );

   // consumer side (controller + MAC datapath)
   modport slave (
      output start, idx_ready,
      input  idx_valid, in_idx, out_idx, first, last, busy, done
   );
endinterface

// File: rtl/layer_index_sequencer.sv
// Walks every (output neuron, input element) pair of one autoencoder layer
// under a valid/ready handshake. Every output is a flop, so out_idx is
// glitch-free for the downstream neuron-index register. first/last are
// computed from the next-state counters and registered, which gives the
// same cycle behaviour as decoding the current counters while keeping the
// outputs free of combinational paths.
`timescale 1ns/1ps
module layer_index_sequencer #(
   parameter int N_IN  = 16,
   parameter int N_OUT = 8,
   parameter int CW    = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   layer_index_sequencer_if.master      bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Terminal values: counters stop at N-1 and never reach N.
   localparam logic [CW-1:0] IN_LAST  = CW'(N_IN - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(N_OUT - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state_q,  state_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] out_cnt_q, out_cnt_d;
   logic          valid_q,  valid_d;
   logic          first_q,  first_d;
   logic          last_q,   last_d;
   logic          busy_q,   busy_d;
   logic          done_q,   done_d;
   logic          handshake_s;

   assign handshake_s = valid_q & bus.idx_ready;

   // Next-state, counter advance and next-output decode.
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_cnt_d  = CNT_ZERO;
            out_cnt_d = CNT_ZERO;
            if (bus.start) begin
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (handshake_s) begin
               if (in_cnt_q < IN_LAST) begin
                  in_cnt_d = in_cnt_q + CNT_ONE;
               end else if (out_cnt_q < OUT_LAST) begin
                  in_cnt_d  = CNT_ZERO;
                  out_cnt_d = out_cnt_q + CNT_ONE;
               end else begin
                  // final term of the final neuron: layer complete
                  in_cnt_d  = CNT_ZERO;
                  out_cnt_d = CNT_ZERO;
                  state_d   = S_DONE;
                  done_d    = 1'b1;
               end
            end else begin
               // stalled: everything holds
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            // start is deliberately not looked at here
            in_cnt_d  = CNT_ZERO;
            out_cnt_d = CNT_ZERO;
            state_d   = S_IDLE;
         end
         default: begin
            in_cnt_d  = CNT_ZERO;
            out_cnt_d = CNT_ZERO;
            state_d   = S_IDLE;
         end
      endcase

      valid_d = (state_d == S_RUN);
      busy_d  = (state_d == S_RUN) || (state_d == S_DONE);
      first_d = valid_d && (in_cnt_d == CNT_ZERO);
      last_d  = valid_d && (in_cnt_d == IN_LAST);
   end

   // State, counter and output registers; reset clears them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         in_cnt_q  <= CNT_ZERO;
         out_cnt_q <= CNT_ZERO;
         valid_q   <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         valid_q   <= valid_d;
         first_q   <= first_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.idx_valid = valid_q;
   assign bus.in_idx    = in_cnt_q;
   assign bus.out_idx   = out_cnt_q;
   assign bus.first     = first_q;
   assign bus.last      = last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule
